fifo_wr_arbiter: RTL

- Shares the single write port of the team's synchronous FIFO between NREQ requesters using round-robin bursts.
- Sits directly in front of the FIFO:
  - drives its write enable and write data;
  - watches its full flag;
  - returns a per-beat accept strobe to each requester.
- Guarantees fairness. No requester holds the port for more than MAX_BURST consecutive beats.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Purpose : shared types and defaults for the FIFO write-port arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: arbiter state enum, default NREQ/WIDTH/MAX_BURST, statistics width.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF      = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int STAT_W        = 16;

endpackage

// File: rtl/rr_pick.sv
// Purpose : combinational round-robin selector; first requester above i_last_ptr wins.
// Latency : zero cycles (pure combinational).
// Backpressure: none; o_vld is low when no request bit is set.
// Ports   : i_req (request vector), i_last_ptr (previous winner),
//           o_vld (some request present), o_idx (winning index).
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_last_ptr,
    output logic            o_vld,
    output logic [PW-1:0]   o_idx
);

    int w_cand;

    // Walk from the farthest candidate to the nearest so the nearest
    // requesting index above i_last_ptr is the one left standing.
    always_comb begin
        o_vld  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = (int'(i_last_ptr) + k) % NREQ;
            if (i_req[w_cand]) begin
                o_vld = 1'b1;
                o_idx = PW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// Latency : one idle arbitration cycle per grant, then one beat per cycle (gnt/fifo_w_en combinational).
// Backpressure: fifo_full stalls the burst in place; owner's req low ends the burst.
// Ports   : clk, rst (sync, active-high); req/req_data in; gnt one-hot accept out;
//           fifo_full in, fifo_w_en/fifo_datain out; busy, owner status;
//           stat_sel in / stat_cnt out (per-requester beat counters when ARB_STATS_EN
//           is defined, otherwise stat_cnt is tied to zero).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ      = NREQ_DEF,
    parameter  int WIDTH     = WIDTH_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int PW        = $clog2(NREQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    input  logic                    fifo_full,
    output logic                    fifo_w_en,
    output logic [WIDTH-1:0]        fifo_datain,
    output logic                    busy,
    output logic [PW-1:0]           owner,
    input  logic [PW-1:0]           stat_sel,
    output logic [STAT_W-1:0]       stat_cnt
);

    arb_state_t     r_state;
    logic [PW-1:0]  r_owner;
    logic [PW-1:0]  r_last_ptr;
    logic [CW-1:0]  r_cnt;

    logic           w_pick_vld;
    logic [PW-1:0]  w_pick_idx;
    logic           w_beat;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req      (req),
        .i_last_ptr (r_last_ptr),
        .o_vld      (w_pick_vld),
        .o_idx      (w_pick_idx)
    );

    // A beat moves only for the current owner and only when the FIFO has room,
    // so a full FIFO can never be written.
    assign w_beat      = (r_state == BURST) && req[r_owner] && !fifo_full;

    assign gnt         = w_beat ? (NREQ'(1) << r_owner) : '0;
    assign fifo_w_en   = w_beat;
    assign fifo_datain = w_beat ? req_data[r_owner*WIDTH +: WIDTH] : '0;
    assign busy        = (r_state == BURST);
    assign owner       = r_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_last_ptr <= PW'(NREQ - 1);
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld && !fifo_full) begin
                        r_owner <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (!req[r_owner]) begin
                        r_state    <= IDLE;
                        r_last_ptr <= r_owner;
                    end else if (!fifo_full) begin
                        r_cnt <= r_cnt + CW'(1);
                        // Last permitted beat of this grant: hand the port on.
                        if (r_cnt == CW'(MAX_BURST - 1)) begin
                            r_state    <= IDLE;
                            r_last_ptr <= r_owner;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_stat[i] <= '0;
            end
        end else if (w_beat && (r_stat[r_owner] != '1)) begin
            r_stat[r_owner] <= r_stat[r_owner] + STAT_W'(1);
        end
    end

    assign stat_cnt = r_stat[stat_sel];
`else
    logic w_unused_stat_sel;
    assign w_unused_stat_sel = ^stat_sel;
    assign stat_cnt          = '0;
`endif

endmodule
